// File: rtl/ceespu_regwrite_ctrl.sv
// ceespu_regwrite_ctrl: owns the single regfile write port.
// After reset it optionally zeroes r1..r(N-1), then arbitrates ALU and load
// writebacks round-robin over valid/ready handshakes. Write-port outputs are registered.
module ceespu_regwrite_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_WIDTH      = 5,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  I_clk,
    input  logic                  I_rst,

    input  logic                  I_alu_valid,
    input  logic [SEL_WIDTH-1:0]  I_alu_sel,
    input  logic [DATA_WIDTH-1:0] I_alu_data,
    output logic                  O_alu_ready,

    input  logic                  I_mem_valid,
    input  logic [SEL_WIDTH-1:0]  I_mem_sel,
    input  logic [DATA_WIDTH-1:0] I_mem_data,
    output logic                  O_mem_ready,

    output logic                  O_we,
    output logic [SEL_WIDTH-1:0]  O_selD,
    output logic [DATA_WIDTH-1:0] O_dataD,
    output logic                  O_busy
);

    localparam logic [SEL_WIDTH-1:0]  SEL_ZERO  = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0]  SEL_FIRST = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0]  SEL_LAST  = {SEL_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    last_mem_q, last_mem_d;
    logic                    we_q, we_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;

    logic                    run_c;
    logic                    contended_c;
    logic                    grant_alu_c;
    logic                    grant_mem_c;
    logic                    xfer_alu_c;
    logic                    xfer_mem_c;

    // State register
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave CLEAR once the last register's write is issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == SEL_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Round-robin arbiter: on a tie, the loser of the previous tie wins
    always_comb begin
        run_c       = (state_q == ST_RUN) && !I_rst;
        contended_c = I_alu_valid && I_mem_valid;
        grant_mem_c = I_mem_valid && (!I_alu_valid || !last_mem_q);
        grant_alu_c = I_alu_valid && (!I_mem_valid || last_mem_q);
        xfer_alu_c  = run_c && grant_alu_c;
        xfer_mem_c  = run_c && grant_mem_c;
    end

    // Ready only ever follows a grant, so it never rises without its valid
    assign O_alu_ready = xfer_alu_c;
    assign O_mem_ready = xfer_mem_c;

    // Output/datapath next values per state
    always_comb begin
        cnt_d      = cnt_q;
        last_mem_d = last_mem_q;
        we_d       = 1'b0;
        sel_d      = sel_q;
        data_d     = data_q;
        busy_d     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                we_d   = 1'b1;
                sel_d  = cnt_q;
                data_d = DATA_ZERO;
                // busy drops together with the final clear write
                busy_d = (cnt_q != SEL_LAST);
                if (cnt_q != SEL_LAST) begin
                    cnt_d = cnt_q + SEL_FIRST;
                end
            end
            ST_RUN: begin
                if (xfer_mem_c) begin
                    we_d   = (I_mem_sel != SEL_ZERO);
                    sel_d  = I_mem_sel;
                    data_d = I_mem_data;
                end else if (xfer_alu_c) begin
                    we_d   = (I_alu_sel != SEL_ZERO);
                    sel_d  = I_alu_sel;
                    data_d = I_alu_data;
                end
                if (contended_c && run_c) begin
                    last_mem_d = grant_mem_c;
                end
            end
            default: begin
                we_d = 1'b0;
            end
        endcase
    end

    // Registered write port, clear counter and arbiter history
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt_q      <= SEL_FIRST;
            last_mem_q <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= SEL_ZERO;
            data_q     <= DATA_ZERO;
            busy_q     <= CLEAR_ON_RESET;
        end else begin
            cnt_q      <= cnt_d;
            last_mem_q <= last_mem_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    assign O_we    = we_q;
    assign O_selD  = sel_q;
    assign O_dataD = data_q;
    assign O_busy  = busy_q;

endmodule

// File: tb/tb_ceespu_regwrite_ctrl.sv
// Self-checking bench for ceespu_regwrite_ctrl: clear sequence, directed
// handshake table, random traffic against an abstract model, reset corner cases.
module tb_ceespu_regwrite_ctrl;

    logic        clk;
    logic        rst;
    logic        rst0;
    logic        alu_v;
    logic [4:0]  alu_sel;
    logic [31:0] alu_dat;
    logic        mem_v;
    logic [4:0]  mem_sel;
    logic [31:0] mem_dat;

    logic        ar, mr, we, busy;
    logic [4:0]  sel;
    logic [31:0] dat;
    logic        ar0, mr0, we0, busy0;
    logic [4:0]  sel0;
    logic [31:0] dat0;

    int checks;
    int errors;

    ceespu_regwrite_ctrl dut (
        .I_clk(clk), .I_rst(rst),
        .I_alu_valid(alu_v), .I_alu_sel(alu_sel), .I_alu_data(alu_dat), .O_alu_ready(ar),
        .I_mem_valid(mem_v), .I_mem_sel(mem_sel), .I_mem_data(mem_dat), .O_mem_ready(mr),
        .O_we(we), .O_selD(sel), .O_dataD(dat), .O_busy(busy)
    );

    ceespu_regwrite_ctrl #(.CLEAR_ON_RESET(1'b0)) dut0 (
        .I_clk(clk), .I_rst(rst0),
        .I_alu_valid(alu_v), .I_alu_sel(alu_sel), .I_alu_data(alu_dat), .O_alu_ready(ar0),
        .I_mem_valid(mem_v), .I_mem_sel(mem_sel), .I_mem_data(mem_dat), .O_mem_ready(mr0),
        .O_we(we0), .O_selD(sel0), .O_dataD(dat0), .O_busy(busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        av;
        logic [4:0]  asel;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  msel;
        logic [31:0] mdat;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [4:0]  esel;
        logic [31:0] edat;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic av, input int asel, input int adat,
                                input logic mv, input int msel, input int mdat,
                                input logic ear, input logic emr,
                                input logic ewe, input int esel, input int edat);
        vec_t v;
        v.av = av;  v.asel = 5'(asel); v.adat = 32'(adat);
        v.mv = mv;  v.msel = 5'(msel); v.mdat = 32'(mdat);
        v.ear = ear; v.emr = emr;
        v.ewe = ewe; v.esel = 5'(esel); v.edat = 32'(edat);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Abstract model state: ties alternate mem, alu, mem, ... counted from reset
    int          ties;
    logic        exp_we;
    logic [4:0]  exp_sel;
    logic [31:0] exp_dat;

    initial begin
        checks  = 0;
        errors  = 0;
        ties    = 0;
        rst     = 1'b1;
        rst0    = 1'b1;
        alu_v   = 1'b1; alu_sel = 5'd9; alu_dat = 32'h99;
        mem_v   = 1'b1; mem_sel = 5'd7; mem_dat = 32'h77;

        tbl[0]  = mk(1, 20, 100, 0,  0,   0, 1, 0, 1, 20, 100);
        tbl[1]  = mk(0,  0,   0, 0,  0,   0, 0, 0, 0, 20, 100);
        tbl[2]  = mk(1, 20, 300, 1, 21, 200, 0, 1, 1, 21, 200);
        tbl[3]  = mk(1, 20, 300, 1, 21, 200, 1, 0, 1, 20, 300);
        tbl[4]  = mk(1, 20, 300, 1, 21, 200, 0, 1, 1, 21, 200);
        tbl[5]  = mk(1, 20, 300, 1, 21, 200, 1, 0, 1, 20, 300);
        tbl[6]  = mk(0,  0,   0, 1, 21, 200, 0, 1, 1, 21, 200);
        tbl[7]  = mk(0,  0,   0, 1,  0,  55, 0, 1, 0,  0,  55);
        tbl[8]  = mk(0,  0,   0, 0,  0,   0, 0, 0, 0,  0,  55);
        tbl[9]  = mk(0,  0,   0, 1,  3, 'hA, 0, 1, 1,  3, 'hA);
        tbl[10] = mk(1,  4, 'hB, 1,  5, 'hC, 0, 1, 1,  5, 'hC);
        tbl[11] = mk(1,  4, 'hB, 0,  0,   0, 1, 0, 1,  4, 'hB);
        tbl[12] = mk(1,  6, 'hD, 1,  6, 'hE, 1, 0, 1,  6, 'hD);
        tbl[13] = mk(1,  6, 'hF, 1,  6, 'hE, 0, 1, 1,  6, 'hE);
        tbl[14] = mk(0,  0,   0, 0,  0,   0, 0, 0, 0,  6, 'hE);

        // Reset state with both valids high
        #2;
        chk("rst_we",    32'(we),   32'd0);
        chk("rst_sel",   32'(sel),  32'd0);
        chk("rst_data",  dat,       32'd0);
        chk("rst_busy",  32'(busy), 32'd1);
        chk("rst_ardy",  32'(ar),   32'd0);
        chk("rst_mrdy",  32'(mr),   32'd0);
        chk("rst0_busy", 32'(busy0), 32'd0);
        chk("rst0_ardy", 32'(ar0),  32'd0);

        // Clear sequence r1..r31
        cyc();
        rst = 1'b0;
        chk("clr_pre_we",   32'(we),   32'd0);
        chk("clr_pre_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 31; k++) begin
            cyc();
            chk("clr_we",   32'(we),   32'd1);
            chk("clr_sel",  32'(sel),  32'(k));
            chk("clr_data", dat,       32'd0);
            chk("clr_busy", 32'(busy), (k < 31) ? 32'd1 : 32'd0);
            if (k < 31) begin
                chk("clr_ardy", 32'(ar), 32'd0);
                chk("clr_mrdy", 32'(mr), 32'd0);
            end
            if (k == 30) begin
                alu_v = 1'b0;
                mem_v = 1'b0;
            end
        end

        // Directed handshake table
        for (int i = 0; i < 15; i++) begin
            alu_v = tbl[i].av; alu_sel = tbl[i].asel; alu_dat = tbl[i].adat;
            mem_v = tbl[i].mv; mem_sel = tbl[i].msel; mem_dat = tbl[i].mdat;
            if (tbl[i].av && tbl[i].mv) ties++;
            #1;
            chk($sformatf("tbl%0d_ardy", i), 32'(ar), 32'(tbl[i].ear));
            chk($sformatf("tbl%0d_mrdy", i), 32'(mr), 32'(tbl[i].emr));
            cyc();
            chk($sformatf("tbl%0d_we", i),   32'(we),  32'(tbl[i].ewe));
            chk($sformatf("tbl%0d_sel", i),  32'(sel), 32'(tbl[i].esel));
            chk($sformatf("tbl%0d_data", i), dat,      tbl[i].edat);
        end
        exp_sel = tbl[14].esel;
        exp_dat = tbl[14].edat;

        // Random traffic against the model
        begin
            logic a_pend, m_pend, win_a, win_m;
            a_pend = 1'b0;
            m_pend = 1'b0;
            for (int n = 0; n < 1500; n++) begin
                if (!a_pend) begin
                    alu_v   = 1'($urandom_range(0, 1));
                    alu_sel = 5'($urandom_range(0, 31));
                    alu_dat = $urandom;
                end
                if (!m_pend) begin
                    mem_v   = 1'($urandom_range(0, 1));
                    mem_sel = 5'($urandom_range(0, 31));
                    mem_dat = $urandom;
                end
                win_a = 1'b0;
                win_m = 1'b0;
                if (alu_v && mem_v) begin
                    if (ties % 2 == 0) win_m = 1'b1;
                    else               win_a = 1'b1;
                    ties++;
                end else begin
                    win_a = alu_v;
                    win_m = mem_v;
                end
                #1;
                chk("rnd_ardy", 32'(ar), 32'(win_a));
                chk("rnd_mrdy", 32'(mr), 32'(win_m));
                exp_we = 1'b0;
                if (win_a) begin
                    exp_we = (alu_sel != 5'd0); exp_sel = alu_sel; exp_dat = alu_dat;
                end else if (win_m) begin
                    exp_we = (mem_sel != 5'd0); exp_sel = mem_sel; exp_dat = mem_dat;
                end
                a_pend = alu_v && !win_a;
                m_pend = mem_v && !win_m;
                cyc();
                chk("rnd_we",   32'(we),   32'(exp_we));
                chk("rnd_sel",  32'(sel),  32'(exp_sel));
                chk("rnd_data", dat,       exp_dat);
                chk("rnd_busy", 32'(busy), 32'd0);
            end
        end

        // Reset mid-RUN: immediate reset values, then clear restarts
        alu_v = 1'b0;
        mem_v = 1'b0;
        rst   = 1'b1;
        #1;
        chk("rrun_we",   32'(we),   32'd0);
        chk("rrun_sel",  32'(sel),  32'd0);
        chk("rrun_data", dat,       32'd0);
        chk("rrun_busy", 32'(busy), 32'd1);
        cyc();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("clr2_sel", 32'(sel), 32'(k));
        end

        // Reset mid-clear in the r10 cycle, held two cycles
        rst = 1'b1;
        #1;
        chk("rclr_we",   32'(we),   32'd0);
        chk("rclr_sel",  32'(sel),  32'd0);
        chk("rclr_busy", 32'(busy), 32'd1);
        cyc();
        cyc();
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            cyc();
            chk("clr3_we",   32'(we),   32'd1);
            chk("clr3_sel",  32'(sel),  32'(k));
            chk("clr3_busy", 32'(busy), (k < 31) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("clr3_end_we",  32'(we),  32'd0);
        chk("clr3_end_sel", 32'(sel), 32'd31);

        // No-clear variant with ALU valid held through reset
        alu_v = 1'b1; alu_sel = 5'd11; alu_dat = 32'h1234;
        #1;
        chk("nc_rst_ardy", 32'(ar0),   32'd0);
        chk("nc_rst_busy", 32'(busy0), 32'd0);
        chk("nc_rst_we",   32'(we0),   32'd0);
        cyc();
        rst0 = 1'b0;
        #1;
        chk("nc_ardy", 32'(ar0), 32'd1);
        chk("nc_mrdy", 32'(mr0), 32'd0);
        cyc();
        alu_v = 1'b0;
        chk("nc_we",   32'(we0),   32'd1);
        chk("nc_sel",  32'(sel0),  32'd11);
        chk("nc_data", dat0,       32'h1234);
        chk("nc_busy", 32'(busy0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
